// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding and default widths.
package mem_port_arbiter_pkg;

  localparam int CORE_COUNT_DEF = 2;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int REG_WIDTH_DEF  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Width of a core index; a single core still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin pick: first requesting core at or after last_grant+1 (mod core_count).
// Combinational, zero latency; no backpressure of its own.
module rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int core_count = CORE_COUNT_DEF
) (
  input  logic [core_count-1:0]            req,
  input  logic [idx_width(core_count)-1:0] last_grant,
  output logic [idx_width(core_count)-1:0] grant,
  output logic                             valid
);

  localparam int gw = idx_width(core_count);

  logic [gw-1:0] cand;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < core_count; i++) begin
      cand = gw'((int'(last_grant) + 1 + i) % core_count);
      if (!valid && req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data RAM among core_count cores, round-robin, one access per 3 cycles.
// Latency 3 cycles req-to-ack; backpressure: each core holds req until its one-cycle ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int core_count = CORE_COUNT_DEF,
  parameter int addr_width = ADDR_WIDTH_DEF,
  parameter int reg_width  = REG_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [core_count-1:0]            req,
  input  logic [core_count-1:0]            we,
  input  logic [addr_width*core_count-1:0] address,
  input  logic [reg_width*core_count-1:0]  wdata,
  output logic [core_count-1:0]            ack,
  output logic [reg_width*core_count-1:0]  rdata,
  output logic [addr_width-1:0]            ram_addr,
  output logic [reg_width-1:0]             ram_din,
  output logic                             ram_wren,
  input  logic [reg_width-1:0]             ram_q
);

  localparam int gw = idx_width(core_count);

  arb_state_t      state, state_nxt;
  logic [gw-1:0]   last_grant, grant_q, pick_idx;
  logic            pick_vld, lat_we;
  logic [core_count-1:0] ack_q;

  rr_pick #(.core_count(core_count)) u_rr_pick (
    .req       (req),
    .last_grant(last_grant),
    .grant     (pick_idx),
    .valid     (pick_vld)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ack_q      <= '0;
      ram_wren   <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      rdata      <= '0;
      last_grant <= gw'(core_count - 1);
      grant_q    <= '0;
      lat_we     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ram_wren <= 1'b0;
      ack_q    <= '0;
      case (state)
        IDLE: begin
          // RAM-side registers are loaded here so they are valid for the whole ISSUE cycle.
          if (pick_vld) begin
            grant_q  <= pick_idx;
            lat_we   <= we[pick_idx];
            ram_wren <= we[pick_idx];
            ram_addr <= address[int'(pick_idx)*addr_width +: addr_width];
            ram_din  <= wdata[int'(pick_idx)*reg_width +: reg_width];
          end
        end
        ISSUE: ack_q[grant_q] <= 1'b1;
        WAIT: begin
          if (!lat_we) rdata[int'(grant_q)*reg_width +: reg_width] <= ram_q;
          last_grant <= grant_q;
        end
        default: ;
      endcase
    end
  end

  // A reset landing in the WAIT cycle abandons the access, so the pulse is suppressed too.
  assign ack = ack_q & ~{core_count{reset}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int RW = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] address;
  logic [N*RW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [N*RW-1:0] rdata;
  logic [AW-1:0]   ram_addr;
  logic [RW-1:0]   ram_din;
  logic            ram_wren;
  logic [RW-1:0]   ram_q;

  mem_port_arbiter #(.core_count(N), .addr_width(AW), .reg_width(RW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address), .wdata(wdata),
    .ack(ack), .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RAM environment and the model's own view of memory
  logic [RW-1:0] ram    [4096];
  logic [RW-1:0] shadow [4096];
  logic [AW-1:0] s_addr;
  logic [RW-1:0] s_din;
  logic          s_wren;

  // Transaction-level model: one pending access scheduled by the edge at which it was granted
  logic [N-1:0]  e_ack;
  logic          e_wren;
  logic [AW-1:0] e_addr;
  logic [RW-1:0] e_din;
  logic [RW-1:0] e_rdata [N];
  int            m_last;
  bit            p_vld;
  int            p_edge, p_core;
  bit            p_we;
  logic [AW-1:0] p_addr;
  logic [RW-1:0] p_din;
  int            edge_n = 0;
  bit            started = 0;
  logic [N-1:0]  ack_s;
  int            ack_core[$];
  int            ack_edge[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [N*RW-1:0] er;
    s_addr = ram_addr;
    s_din  = ram_din;
    s_wren = ram_wren;
    ack_s  = ack;
    if (!started) return;
    for (int i = 0; i < N; i++) er[i*RW +: RW] = e_rdata[i];
    chk("ack",      64'(ack),      64'(reset ? '0 : e_ack));
    chk("ram_wren", 64'(ram_wren), 64'(e_wren));
    chk("ram_addr", 64'(ram_addr), 64'(e_addr));
    chk("ram_din",  64'(ram_din),  64'(e_din));
    chk("rdata",    64'(rdata),    64'(er));
    for (int i = 0; i < N; i++)
      if (ack[i]) begin
        ack_core.push_back(i);
        ack_edge.push_back(edge_n);
      end
  endtask

  task automatic model_step();
    int  c;
    bit  found;
    edge_n++;
    if (reset) begin
      if (p_vld && edge_n == p_edge + 1 && p_we) shadow[p_addr] = p_din;
      p_vld  = 0;
      e_ack  = '0;
      e_wren = 1'b0;
      e_addr = '0;
      e_din  = '0;
      for (int i = 0; i < N; i++) e_rdata[i] = '0;
      m_last = N - 1;
    end else begin
      e_ack  = '0;
      e_wren = 1'b0;
      if (p_vld && edge_n == p_edge + 1) begin
        e_ack[p_core] = 1'b1;
        if (p_we) shadow[p_addr] = p_din;
      end else if (p_vld) begin
        if (!p_we) e_rdata[p_core] = shadow[p_addr];
        m_last = p_core;
        p_vld  = 0;
      end else if (req != '0) begin
        found = 0;
        c = 0;
        for (int k = 1; k <= N; k++)
          if (!found && req[(m_last + k) % N]) begin
            c = (m_last + k) % N;
            found = 1;
          end
        p_vld  = 1;
        p_edge = edge_n;
        p_core = c;
        p_we   = we[c];
        p_addr = address[c*AW +: AW];
        p_din  = wdata[c*RW +: RW];
        e_wren = p_we;
        e_addr = p_addr;
        e_din  = p_din;
      end
    end
    started = 1;
  endtask

  // One clock: compare at the falling edge, advance model at the rising edge, then RAM responds.
  task automatic cyc();
    logic [RW-1:0] q;
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
    q = ram[s_addr];
    if (s_wren) ram[s_addr] = s_din;
    ram_q = q;
  endtask

  task automatic set_core(input int i, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [RW-1:0] d);
    req[i] = r;
    we[i]  = w;
    address[i*AW +: AW] = a;
    wdata[i*RW +: RW]   = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    we    = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int e0;
    reset = 1'b1; req = '0; we = '0; address = '0; wdata = '0; ram_q = '0;
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = RW'(i * 37 + 5);
      shadow[i] = ram[i];
    end

    // Reset state
    do_reset();
    chk("rst_ack",   64'(ack), 0);
    chk("rst_wren",  64'(ram_wren), 0);
    chk("rst_addr",  64'(ram_addr), 0);
    chk("rst_rdata", 64'(rdata), 0);

    // Core0 write 0x010 <- 0x0AB: strobe in cycle 2, ack in cycle 3
    set_core(0, 1'b1, 1'b1, 12'h010, 12'h0AB);
    cyc();
    chk("wr_c2_wren", 64'(ram_wren), 1);
    chk("wr_c2_addr", 64'(ram_addr), 64'h010);
    chk("wr_c2_din",  64'(ram_din),  64'h0AB);
    chk("model_wren_c2", 64'(e_wren), 1);
    cyc();
    chk("wr_c3_ack",  64'(ack), 64'b0001);
    chk("wr_c3_wren", 64'(ram_wren), 0);
    cyc();
    req[0] = 1'b0;

    // Core1 reads it back; slice 0 untouched
    set_core(1, 1'b1, 1'b0, 12'h010, 12'h000);
    cyc();
    chk("rd_c2_wren", 64'(ram_wren), 0);
    chk("rd_c2_addr", 64'(ram_addr), 64'h010);
    cyc();
    chk("rd_c3_ack", 64'(ack), 64'b0010);
    cyc();
    req[1] = 1'b0;
    chk("rd_slice1", 64'(rdata[RW +: RW]), 64'h0AB);
    chk("rd_slice0", 64'(rdata[0 +: RW]), 0);
    chk("model_rdata1", 64'(e_rdata[1]), 64'h0AB);

    // Both cores held high from reset: grants 0,1,0,1 every 3 cycles
    do_reset();
    e0 = edge_n;
    ack_core.delete(); ack_edge.delete();
    set_core(0, 1'b1, 1'b0, 12'h100, 12'h0);
    set_core(1, 1'b1, 1'b0, 12'h101, 12'h0);
    for (int i = 0; i < 13; i++) cyc();
    req = '0;
    chk("both_nacks", 64'(ack_core.size()), 4);
    if (ack_core.size() >= 4) begin
      chk("both_g0", 64'(ack_core[0]), 0);
      chk("both_g1", 64'(ack_core[1]), 1);
      chk("both_g2", 64'(ack_core[2]), 0);
      chk("both_g3", 64'(ack_core[3]), 1);
      chk("both_first_lat", 64'(ack_edge[0] - e0), 2);
      for (int i = 1; i < 4; i++)
        chk("both_spacing", 64'(ack_edge[i] - ack_edge[i-1]), 3);
    end

    // Core0 drops req during ISSUE; access still completes
    do_reset();
    set_core(0, 1'b1, 1'b1, 12'h020, 12'h155);
    cyc();
    req[0] = 1'b0;
    cyc();
    chk("drop_ack", 64'(ack), 64'b0001);
    cyc();
    cyc();
    chk("drop_ram", 64'(ram[12'h020]), 64'h155);

    // Reset during WAIT: no ack, and core 0 wins next even though core 1 was in flight
    do_reset();
    set_core(0, 1'b1, 1'b0, 12'h030, 12'h0);
    cyc(); cyc(); cyc();
    req[0] = 1'b0;
    set_core(0, 1'b1, 1'b0, 12'h031, 12'h0);
    set_core(1, 1'b1, 1'b0, 12'h032, 12'h0);
    cyc();
    chk("rstw_grant1", 64'(ram_addr), 64'h032);
    cyc();
    reset = 1'b1;
    #1;
    chk("rstw_noack", 64'(ack), 0);
    cyc();
    reset = 1'b0;
    ack_core.delete(); ack_edge.delete();
    for (int i = 0; i < 4; i++) cyc();
    req = '0;
    chk("rstw_nacks", 64'(ack_core.size()), 1);
    if (ack_core.size() >= 1) chk("rstw_next_core", 64'(ack_core[0]), 0);

    // Only core2 requesting, held: granted every access, 3 cycles apart
    do_reset();
    ack_core.delete(); ack_edge.delete();
    set_core(2, 1'b1, 1'b1, 12'h040, 12'h3C3);
    for (int i = 0; i < 10; i++) cyc();
    req = '0;
    chk("c2_nacks", 64'(ack_core.size()), 3);
    for (int i = 0; i < ack_core.size(); i++) chk("c2_core", 64'(ack_core[i]), 2);
    for (int i = 1; i < ack_core.size(); i++)
      chk("c2_spacing", 64'(ack_edge[i] - ack_edge[i-1]), 3);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      cyc();
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (ack_s[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0)
          set_core(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), RW'($urandom));
        else if (req[i] && $urandom_range(0, 39) == 0)
          req[i] = 1'b0;
      end
    end
    reset = 1'b0;
    req = '0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter core_count, default 2, meaning number of requesting cores.
REQ-002 SHALL have parameter addr_width, default 12, meaning data-memory address width.
REQ-003 SHALL have parameter reg_width, default 12, meaning data word width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req, input, core_count, per-core access request, held until ack.
REQ-007 SHALL have port we, input, core_count, per-core write enable (1 = write, 0 = read).
REQ-008 SHALL have port address, input, addr_width*core_count, per-core addresses; core i occupies slice [i*addr_width +: addr_width].
REQ-009 SHALL have port wdata, input, reg_width*core_count, per-core write data, sliced the same way.
REQ-010 SHALL have port ack, output, core_count, one-cycle completion pulse per core.
REQ-011 SHALL have port rdata, output, reg_width*core_count, per-core registered read data.
REQ-012 SHALL have port ram_addr, output, addr_width, address to the single-port data RAM.
REQ-013 SHALL have port ram_din, output, reg_width, write data to the RAM.
REQ-014 SHALL have port ram_wren, output, 1, RAM write strobe.
REQ-015 SHALL have port ram_q, input, reg_width, RAM read data, valid exactly one cycle after the address is presented.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-017 IDLE: if req is nonzero, the block SHALL grant one core round-robin, searching from last_grant+1 modulo core_count, latch that core's address, wdata and we, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 ISSUE: the block SHALL drive ram_addr and ram_din from the latched values, drive ram_wren equal to the latched we for this cycle only, and go to WAIT.
REQ-019 WAIT: the block SHALL assert ack[grant] for exactly one cycle; for a read it SHALL load ram_q into rdata slice [grant] at the same edge; it SHALL set last_grant equal to grant and go to IDLE.
REQ-020 Latency SHALL be 3 cycles from req sampled in IDLE to ack high; peak throughput SHALL be one access per 3 cycles.
REQ-021 ram_wren SHALL be 0 in IDLE and WAIT; ram_addr and ram_din SHALL hold their last latched values outside ISSUE.
REQ-022 rdata slices of non-granted cores, and all slices on a write, SHALL hold their previous values.
REQ-023 Requesters SHALL deassert req at the edge on which they sample ack; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-024 A req dropped after being latched SHALL NOT abort the access; the access SHALL complete and ack SHALL still pulse.
REQ-025 A core with req held continuously SHALL NOT be granted twice in a row while another core's req is high (no starvation; worst-case wait of core_count-1 accesses).
REQ-026 Requests arriving while the FSM is in ISSUE or WAIT SHALL NOT be sampled until the next IDLE.

Reset
REQ-027 On reset the block SHALL set state to IDLE, ack to 0, ram_wren to 0, ram_addr to 0, ram_din to 0, rdata to 0, and last_grant to core_count-1, so that core 0 has first priority.
REQ-028 Reset in ISSUE or WAIT SHALL abandon the access with no ack, and ram_wren SHALL be 0 from the next cycle.

Structure
REQ-029 The state encoding (IDLE=0, ISSUE=1, WAIT=2) SHALL reside in the shared processor package, together with the default widths.
REQ-030 The round-robin select SHALL be a combinational sub-module rr_pick (inputs req and last_grant; outputs grant index and valid).

Verification
REQ-031 Reset, then core0 writes addr 0x010 with data 0x0AB -> ram_wren=1 with ram_addr=0x010 in cycle 2, ack[0] in cycle 3.
REQ-032 Core1 reads 0x010 with the RAM model returning 0x0AB -> ack[1] in cycle 3 and rdata slice 1 = 0x0AB; slice 0 unchanged.
REQ-033 Both cores request together, continuously, from reset -> grants 0,1,0,1; ack every 3 cycles.
REQ-034 Core0 drops req during ISSUE -> access completes and ack[0] pulses.
REQ-035 Reset asserted during WAIT -> no ack, state IDLE, the next grant goes to core 0.
REQ-036 core_count=4 with only core2 requesting repeatedly -> core2 granted each access, 3-cycle spacing.
